// File: rtl/bw_rf_pkg.sv
// -----------------------------------------------------------------------------
// bw_rf_pkg
//   Shared constants and helpers for the parametrised two-port register file.
//   - RF_RD_OFF      : fill value driven on the read port when no entry is read
//   - RF_RD_LAT_*    : legal read latencies
//   - clog2          : address-width helper
//   - rf_params_ok   : parameter legality check used at elaboration
// -----------------------------------------------------------------------------
package bw_rf_pkg;

    localparam int RF_MAX_W = 128;

    // Wide enough for the largest legal WIDTH; users slice the low bits.
    localparam logic [RF_MAX_W-1:0] RF_RD_OFF = '1;

    localparam int RF_RD_LAT_1 = 1;
    localparam int RF_RD_LAT_2 = 2;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic bit rf_params_ok(input int width, input int depth,
                                        input int aw, input int rd_lat);
        bit ok;
        ok = 1'b1;
        if (width < 1 || width > RF_MAX_W) ok = 1'b0;
        if (depth < 2 || depth > 64)       ok = 1'b0;
        if (aw != clog2(depth))            ok = 1'b0;
        if (rd_lat != RF_RD_LAT_1 && rd_lat != RF_RD_LAT_2) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bw_rf_param_rdpipe.sv
// -----------------------------------------------------------------------------
// bw_rf_param_rdpipe
//   Read output stage of bw_rf_param_2p. Registers read data, the entry-valid
//   flag and the read/write conflict flag together so they stay aligned.
//   RD_LAT=1 gives a single register; RD_LAT=2 adds a leading stage.
//
// Ports
//   rclk     : core clock, posedge
//   reset    : asynchronous, active-high
//   en       : stage advance enable (low while the array is held)
//   data_p0  : read data resolved at the current edge
//   vld_p0   : entry-valid flag for data_p0
//   conf_p0  : read/write same-address flag for data_p0
//   data_q   : read data presented to the output mux
//   vld_q    : aligned entry-valid flag
//   conf_q   : aligned conflict flag
// -----------------------------------------------------------------------------
module bw_rf_param_rdpipe
    import bw_rf_pkg::*;
#(
    parameter int WIDTH  = 81,
    parameter int RD_LAT = 1
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] data_p0,
    input  logic             vld_p0,
    input  logic             conf_p0,
    output logic [WIDTH-1:0] data_q,
    output logic             vld_q,
    output logic             conf_q
);

    localparam logic [WIDTH-1:0] RD_OFF = RF_RD_OFF[WIDTH-1:0];

    generate
        if (RD_LAT == RF_RD_LAT_2) begin : g_lat2
            logic [WIDTH-1:0] data_p1;
            logic             vld_p1;
            logic             conf_p1;

            // ---- stage p1: intermediate register (clears to zero) ----
            always_ff @(posedge rclk or posedge reset) begin
                if (reset) begin
                    data_p1 <= '0;
                    vld_p1  <= 1'b0;
                    conf_p1 <= 1'b0;
                end else if (en) begin
                    data_p1 <= data_p0;
                    vld_p1  <= vld_p0;
                    conf_p1 <= conf_p0;
                end
            end

            // ---- stage p2: output register (clears to the off value) ----
            always_ff @(posedge rclk or posedge reset) begin
                if (reset) begin
                    data_q <= RD_OFF;
                    vld_q  <= 1'b0;
                    conf_q <= 1'b0;
                end else if (en) begin
                    data_q <= data_p1;
                    vld_q  <= vld_p1;
                    conf_q <= conf_p1;
                end
            end
        end else begin : g_lat1
            // ---- stage p1: output register ----
            always_ff @(posedge rclk or posedge reset) begin
                if (reset) begin
                    data_q <= RD_OFF;
                    vld_q  <= 1'b0;
                    conf_q <= 1'b0;
                end else if (en) begin
                    data_q <= data_p0;
                    vld_q  <= vld_p0;
                    conf_q <= conf_p0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/bw_rf_param_2p.sv
// -----------------------------------------------------------------------------
// bw_rf_param_2p
//   Parametrised 1R/1W register file on a single clock edge, with optional
//   write-to-read bypass, per-entry valid tracking, a registered read/write
//   conflict flag and the test features (hold, testmux, listen flop).
//
// Parameters
//   WIDTH  : data width (1..128)
//   DEPTH  : number of entries (2..64)
//   AW     : address width, clog2(DEPTH)
//   RD_LAT : read latency, 1 or 2
//   BYPASS : 1 = same-edge write data forwarded to a colliding read
//
// Ports
//   rclk        : core clock, posedge
//   reset       : asynchronous, active-high
//   csn_rd      : read enable, active low
//   csn_wr      : write enable, active low
//   rd_a, wr_a  : read / write address
//   di          : write data
//   hold        : freeze every register, the array and the valid bitmap
//   testmux_sel : drive dout from the registered write data
//   dout        : read data
//   rd_vld      : read entry had been written since reset (aligned with dout)
//   rw_conflict : read and write hit the same address (aligned with dout)
//   listen_out  : dout captured every non-held edge
// -----------------------------------------------------------------------------
module bw_rf_param_2p
    import bw_rf_pkg::*;
#(
    parameter int WIDTH  = 81,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic             rclk,
    input  logic             reset,
    input  logic             csn_rd,
    input  logic             csn_wr,
    input  logic [AW-1:0]    rd_a,
    input  logic [AW-1:0]    wr_a,
    input  logic [WIDTH-1:0] di,
    input  logic             hold,
    input  logic             testmux_sel,
    output logic [WIDTH-1:0] dout,
    output logic             rd_vld,
    output logic             rw_conflict,
    output logic [WIDTH-1:0] listen_out
);

    generate
        if (!rf_params_ok(WIDTH, DEPTH, AW, RD_LAT)) begin : g_param_err
            $error("bw_rf_param_2p: illegal WIDTH/DEPTH/AW/RD_LAT combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] RD_OFF  = RF_RD_OFF[WIDTH-1:0];
    localparam logic [AW:0]      DEPTH_A = (AW+1)'(DEPTH);
    localparam bit               BYP_EN  = (BYPASS != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] di_ff;

    logic             en;
    logic             rd_hit;
    logic             wr_hit;
    logic             same_a;
    logic             byp_hit;

    logic [WIDTH-1:0] rd_data_p0;
    logic             rd_vld_p0;
    logic             rw_conf_p0;

    logic [WIDTH-1:0] rd_data_q;

    assign en     = ~hold;
    // Addresses at or beyond DEPTH only occur when DEPTH is not a power of two.
    assign rd_hit = ~csn_rd & ({1'b0, rd_a} < DEPTH_A);
    assign wr_hit = ~csn_wr & ({1'b0, wr_a} < DEPTH_A);
    assign same_a = (rd_a == wr_a);
    assign byp_hit = BYP_EN & rd_hit & wr_hit & same_a;

    // The conflict flag reports the raw request collision, bypass or not.
    assign rw_conf_p0 = ~csn_rd & ~csn_wr & same_a;

    // ---- stage p0: read resolved from the array state before this edge ----
    always_comb begin
        rd_data_p0 = RD_OFF;
        rd_vld_p0  = 1'b0;
        if (rd_hit) begin
            if (byp_hit) begin
                rd_data_p0 = di;
                rd_vld_p0  = 1'b1;
            end else begin
                rd_data_p0 = mem[rd_a];
                rd_vld_p0  = valid_q[rd_a];
            end
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge rclk) begin
        if (en && wr_hit) begin
            mem[wr_a] <= di;
        end
    end

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (en && wr_hit) begin
            valid_q[wr_a] <= 1'b1;
        end
    end

    // Write data is captured every non-held edge, independent of csn_wr,
    // so the testmux path can observe the input bus.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            di_ff <= '0;
        end else if (en) begin
            di_ff <= di;
        end
    end

    bw_rf_param_rdpipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .rclk    (rclk),
        .reset   (reset),
        .en      (en),
        .data_p0 (rd_data_p0),
        .vld_p0  (rd_vld_p0),
        .conf_p0 (rw_conf_p0),
        .data_q  (rd_data_q),
        .vld_q   (rd_vld),
        .conf_q  (rw_conflict)
    );

    // Test mux overrides only the data; the flags keep following the read path.
    assign dout = testmux_sel ? di_ff : rd_data_q;

    // ---- listen flop: samples the post-mux output ----
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            listen_out <= '0;
        end else if (en) begin
            listen_out <= dout;
        end
    end

endmodule
